// File: rtl/uart_tx_framer.sv
// UART transmitter that fetches multi-byte words from an upstream FIFO and
// serialises each one as BYTES_PER_WORD frames, most significant byte first.
module uart_tx_framer #(
    parameter int unsigned CLKS_PER_BIT   = 40,
    parameter int unsigned INIT_CLKS      = 400,
    parameter int unsigned BYTES_PER_WORD = 3,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY_MODE    = 0,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_fifo_empty,
    output logic                        o_fifo_pop,
    input  logic [8*BYTES_PER_WORD-1:0] i_fifo_data,
    output logic                        o_uart_tx,
    output logic                        o_busy,
    output logic                        o_word_done
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(INIT_CLKS + 1);
    localparam int unsigned WW = 8 * BYTES_PER_WORD;

    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_PENULT = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CLKS - 1);
    localparam logic [2:0]    DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic [1:0]    BYTE_LAST  = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [IW-1:0]   r_init_cnt;
    logic [2:0]      r_bit_idx;
    logic [1:0]      r_byte_idx;
    logic [WW-1:0]   r_word;
    logic            r_tx;
    logic            r_pop;
    logic            r_busy;
    logic            r_word_done;

    logic [7:0]      w_byte;
    logic            w_bit_end;
    logic            w_data_xor;
    logic            w_parity;
    logic            w_in_frame;

    // The byte on the wire is always the top byte; the word shifts left per frame.
    assign w_byte     = r_word[WW-1 -: 8];
    assign w_bit_end  = (r_clk_cnt == BIT_LAST);
    assign w_data_xor = ^w_byte[DATA_BITS-1:0];
    assign w_parity   = (PARITY_MODE == 2) ? ~w_data_xor : w_data_xor;
    assign w_in_frame = (r_state == StStart) || (r_state == StData) ||
                        (r_state == StParity) || (r_state == StStop);

    // Framer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StInit;
            r_clk_cnt   <= '0;
            r_init_cnt  <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_tx        <= 1'b1;
            r_pop       <= 1'b0;
            r_busy      <= 1'b1;
            r_word_done <= 1'b0;
        end else begin
            r_pop       <= 1'b0;
            r_word_done <= 1'b0;
            if (w_in_frame) begin
                r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
            end
            case (r_state)
                StInit: begin
                    if (r_init_cnt == INIT_LAST) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                StIdle: begin
                    if (!i_fifo_empty) begin
                        r_state <= StFetch;
                        r_pop   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                StFetch: begin
                    r_state <= StLoad;
                end
                StLoad: begin
                    r_word     <= i_fifo_data;
                    r_byte_idx <= '0;
                    r_clk_cnt  <= '0;
                    r_tx       <= 1'b0;
                    r_state    <= StStart;
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_state   <= StData;
                        r_bit_idx <= '0;
                        r_tx      <= w_byte[0];
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == DATA_LAST) begin
                            r_bit_idx <= '0;
                            if (PARITY_MODE != 0) begin
                                r_state <= StParity;
                                r_tx    <= w_parity;
                            end else begin
                                r_state <= StStop;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_byte[r_bit_idx + 3'd1];
                        end
                    end
                end
                StParity: begin
                    if (w_bit_end) begin
                        r_state <= StStop;
                        r_tx    <= 1'b1;
                    end
                end
                StStop: begin
                    // Raised one cycle early so the registered pulse lands on the last stop cycle.
                    if ((r_byte_idx == BYTE_LAST) && (r_bit_idx == STOP_LAST) &&
                        (r_clk_cnt == BIT_PENULT)) begin
                        r_word_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        if (r_bit_idx == STOP_LAST) begin
                            r_bit_idx <= '0;
                            if (r_byte_idx != BYTE_LAST) begin
                                r_byte_idx <= r_byte_idx + 2'd1;
                                r_word     <= r_word << 8;
                                r_state    <= StStart;
                                r_tx       <= 1'b0;
                            end else begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= StInit;
                end
            endcase
        end
    end

    assign o_uart_tx   = r_tx;
    assign o_fifo_pop  = r_pop;
    assign o_busy      = r_busy;
    assign o_word_done = r_word_done;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench: three framer configurations against a bit-list reference model.
module tb_uart_tx_framer;

    localparam int NDUT = 3;
    localparam int P_CPB  [NDUT] = '{40, 6, 5};
    localparam int P_INIT [NDUT] = '{400, 20, 17};
    localparam int P_BPW  [NDUT] = '{3, 1, 2};
    localparam int P_DB   [NDUT] = '{8, 8, 7};
    localparam int P_PM   [NDUT] = '{0, 1, 2};
    localparam int P_SB   [NDUT] = '{1, 1, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_empty [NDUT];
    logic [31:0] r_data  [NDUT];
    logic        w_pop   [NDUT];
    logic        w_tx    [NDUT];
    logic        w_busy  [NDUT];
    logic        w_wd    [NDUT];

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];

    int n_checks = 0;
    int n_fail   = 0;
    int pop_cnt  [NDUT];
    int push_cnt [NDUT];
    logic        pend      [NDUT];
    logic [31:0] pend_word [NDUT];
    logic        prev_pop  [NDUT];

    always #5 clk = ~clk;

    uart_tx_framer #(
        .CLKS_PER_BIT(P_CPB[0]), .INIT_CLKS(P_INIT[0]), .BYTES_PER_WORD(P_BPW[0]),
        .DATA_BITS(P_DB[0]), .PARITY_MODE(P_PM[0]), .STOP_BITS(P_SB[0])
    ) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_fifo_empty(r_empty[0]), .o_fifo_pop(w_pop[0]),
        .i_fifo_data(r_data[0][23:0]), .o_uart_tx(w_tx[0]), .o_busy(w_busy[0]),
        .o_word_done(w_wd[0])
    );

    uart_tx_framer #(
        .CLKS_PER_BIT(P_CPB[1]), .INIT_CLKS(P_INIT[1]), .BYTES_PER_WORD(P_BPW[1]),
        .DATA_BITS(P_DB[1]), .PARITY_MODE(P_PM[1]), .STOP_BITS(P_SB[1])
    ) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_fifo_empty(r_empty[1]), .o_fifo_pop(w_pop[1]),
        .i_fifo_data(r_data[1][7:0]), .o_uart_tx(w_tx[1]), .o_busy(w_busy[1]),
        .o_word_done(w_wd[1])
    );

    uart_tx_framer #(
        .CLKS_PER_BIT(P_CPB[2]), .INIT_CLKS(P_INIT[2]), .BYTES_PER_WORD(P_BPW[2]),
        .DATA_BITS(P_DB[2]), .PARITY_MODE(P_PM[2]), .STOP_BITS(P_SB[2])
    ) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_fifo_empty(r_empty[2]), .o_fifo_pop(w_pop[2]),
        .i_fifo_data(r_data[2][15:0]), .o_uart_tx(w_tx[2]), .o_busy(w_busy[2]),
        .o_word_done(w_wd[2])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic update_empty();
        for (int k = 0; k < NDUT; k++) r_empty[k] = (q_size(k) == 0);
    endtask

    task automatic push_word(input int k, input logic [31:0] w);
        case (k)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            default: q2.push_back(w);
        endcase
        push_cnt[k]++;
        update_empty();
    endtask

    function automatic logic [31:0] word_mask(input int k);
        return 32'((64'd1 << (8 * P_BPW[k])) - 64'd1);
    endfunction

    // Upstream FIFO model: data is valid only in the cycle after the pop, random otherwise.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (pend[k]) begin
                r_data[k] = pend_word[k];
                pend[k]   = 1'b0;
            end else begin
                r_data[k] = $urandom;
            end
            if (w_pop[k] === 1'b1) begin
                check_val($sformatf("pop_width_d%0d", k), prev_pop[k], 0);
                check_val($sformatf("pop_underflow_d%0d", k), r_empty[k], 0);
                pop_cnt[k]++;
                pend[k] = 1'b1;
                case (k)
                    0:       pend_word[k] = (q0.size() > 0) ? q0.pop_front() : 32'h0;
                    1:       pend_word[k] = (q1.size() > 0) ? q1.pop_front() : 32'h0;
                    default: pend_word[k] = (q2.size() > 0) ? q2.pop_front() : 32'h0;
                endcase
                update_empty();
            end
            prev_pop[k] = w_pop[k];
        end
    end

    task automatic measure_init(input int k);
        int cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (w_busy[k] !== 1'b0 && cnt < P_INIT[k] + 50);
        check_val($sformatf("init_len_d%0d", k), cnt, P_INIT[k]);
    endtask

    // Waits for a start bit, then compares every cycle of the word against the bit list.
    task automatic check_word(input int k, input logic [31:0] word, input int exp_gap);
        bit         eb [$];
        logic [7:0] byt;
        int         ones, gap, n_total, bad, wd_hits, wd_last, cpb;
        cpb = P_CPB[k];
        for (int f = 0; f < P_BPW[k]; f++) begin
            byt  = 8'(word >> (8 * (P_BPW[k] - 1 - f)));
            ones = 0;
            eb.push_back(1'b0);
            for (int i = 0; i < P_DB[k]; i++) begin
                eb.push_back(byt[i]);
                ones += int'(byt[i]);
            end
            if (P_PM[k] == 1) eb.push_back(bit'(ones % 2));
            if (P_PM[k] == 2) eb.push_back(bit'(1 - ones % 2));
            for (int s = 0; s < P_SB[k]; s++) eb.push_back(1'b1);
        end
        gap = 0;
        forever begin
            @(negedge clk);
            if (w_tx[k] === 1'b0 || gap > 3000) break;
            gap++;
        end
        check_val($sformatf("start_seen_d%0d", k), w_tx[k], 0);
        if (w_tx[k] !== 1'b0) return;
        if (exp_gap >= 0) check_val($sformatf("gap_d%0d", k), gap, exp_gap);
        n_total = eb.size() * cpb;
        bad     = 0;
        wd_hits = 0;
        wd_last = 0;
        for (int n = 0; n < n_total; n++) begin
            if (n > 0) @(negedge clk);
            if (w_tx[k] !== eb[n / cpb]) bad++;
            if (w_busy[k] !== 1'b1) bad++;
            if (w_wd[k] === 1'b1) wd_hits++;
            if (n == n_total - 1) wd_last = int'(w_wd[k] === 1'b1);
            if (n % cpb == cpb / 2)
                check_val($sformatf("d%0d_bit%0d", k, n / cpb), w_tx[k], eb[n / cpb]);
        end
        check_val($sformatf("wave_exact_d%0d", k), bad, 0);
        check_val($sformatf("word_done_cnt_d%0d", k), wd_hits, 1);
        check_val($sformatf("word_done_last_d%0d", k), wd_last, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] w1, w2;
        int          bad;
        for (int k = 0; k < NDUT; k++) begin
            pop_cnt[k]  = 0;
            push_cnt[k] = 0;
            pend[k]     = 1'b0;
            prev_pop[k] = 1'b0;
        end
        update_empty();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check_val($sformatf("rst_tx_d%0d", k), w_tx[k], 1);
            check_val($sformatf("rst_pop_d%0d", k), w_pop[k], 0);
            check_val($sformatf("rst_busy_d%0d", k), w_busy[k], 1);
            check_val($sformatf("rst_wd_d%0d", k), w_wd[k], 0);
        end
        rst = 1'b0;
        fork
            measure_init(0);
            measure_init(1);
            measure_init(2);
        join

        // Empty FIFO: line idle, not busy, no pops.
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++)
                if (w_tx[k] !== 1'b1 || w_busy[k] !== 1'b0 || w_pop[k] !== 1'b0) bad++;
        end
        check_val("idle_hold", bad, 0);
        check_val("idle_no_pop", pop_cnt[0] + pop_cnt[1] + pop_cnt[2], 0);

        // Directed words.
        push_word(0, 32'hA5C381);
        check_word(0, 32'hA5C381, -1);
        check_val("pops_t1", pop_cnt[0], push_cnt[0]);
        push_word(1, 32'h07);
        check_word(1, 32'h07, -1);
        push_word(2, 32'hFF07);
        check_word(2, 32'hFF07, -1);

        // Back-to-back words: exactly three idle-high cycles between them.
        for (int k = 0; k < NDUT; k++) begin
            w1 = $urandom & word_mask(k);
            w2 = $urandom & word_mask(k);
            push_word(k, w1);
            push_word(k, w2);
            check_word(k, w1, -1);
            check_word(k, w2, 3);
            check_val($sformatf("pops_b2b_d%0d", k), pop_cnt[k], push_cnt[k]);
        end

        // Randomised single words.
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 4; i++) begin
                w1 = $urandom & word_mask(k);
                push_word(k, w1);
                check_word(k, w1, -1);
            end
            check_val($sformatf("pops_rand_d%0d", k), pop_cnt[k], push_cnt[k]);
        end

        // Reset during a data bit that is low: line must return high at once.
        push_word(0, 32'h123456);
        bad = 0;
        do begin
            @(negedge clk);
            bad++;
        end while (w_tx[0] !== 1'b0 && bad < 3000);
        check_val("t5_start_seen", w_tx[0], 0);
        repeat (3 * P_CPB[0]) @(negedge clk);
        check_val("t5_pre_tx", w_tx[0], 0);
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_rst_tx", w_tx[0], 1);
        check_val("t5_rst_pop", w_pop[0], 0);
        check_val("t5_rst_busy", w_busy[0], 1);
        w2 = $urandom & word_mask(0);
        push_word(0, w2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fork
            measure_init(0);
            measure_init(1);
            measure_init(2);
        join
        check_word(0, w2, -1);
        check_val("t5_pops", pop_cnt[0], push_cnt[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
